ks_adder_pipe: RTL and testbench

Parametrised, pipelined Kogge-Stone adder/subtractor built from the team's generate/propagate dot-operator prefix cells. It generalises the single-cell prefix combine to an N-bit log-depth prefix tree with optional per-level pipeline registers, an add/subtract mode, a carry-in, and carry/overflow flags. A valid/ready stream handshake on both sides lets it sit directly in datapath pipelines.

---
 rtl/ks_adder_pipe.sv | 161 ++++++++++++++++
 tb/tb_ks_adder_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: pipelined Kogge-Stone adder/subtractor with a valid/ready stream
// on both sides.
//
// Datapath: bit-level generate/propagate (carry-in folded into bit 0), then
// L = clog2(WIDTH) dot-operator prefix levels, then a sum/flag output register.
// With PIPE=1 every level is registered (latency L+2). With PIPE=0 only the
// output register remains (latency 1).
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset (clears valids only)
//   in_valid / in_ready   operand beat handshake (in_ready = global advance)
//   a, b, cin, sub        operands; sub=1 computes a - b and ignores cin
//   out_valid / out_ready result handshake
//   sum, cout, ovf        result mod 2^WIDTH, carry out of MSB, signed overflow
module ks_adder_pipe #(
  parameter int WIDTH = 16,
  parameter bit PIPE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int L = $clog2(WIDTH);

  logic out_valid_q;
  logic advance;

  // One global enable: every stage moves together, bubbles included, so a
  // stalled output freezes the whole pipe.
  assign advance  = !out_valid_q | out_ready;
  assign in_ready = advance;

  // Level 0 is the bit-level g/p stage; levels 1..L are prefix levels.
  // Each level presents st_* to the next: registered when PIPE=1, a wire otherwise.
  // The raw p vector and c0 ride along so the output stage needs nothing earlier.
  genvar gi;
  for (gi = 0; gi <= L; gi++) begin : lvl
    logic [WIDTH-1:0] g_d, pr_d, st_g, st_pr;
    logic             c0_d, v_d, st_c0, st_v;

    if (gi == 0) begin : g_bit
      logic [WIDTH-1:0] bx, gb, pb;
      always_comb begin
        bx    = sub ? ~b : b;
        c0_d  = sub ? 1'b1 : cin;
        gb    = a & bx;
        pb    = a ^ bx;
        g_d   = gb;
        // Carry-in folded into bit 0 so the prefix tree has no separate cin term.
        g_d[0] = gb[0] | (pb[0] & c0_d);
        pr_d  = pb;
        v_d   = in_valid;
      end
    end else begin : g_pre
      localparam int SPAN = 1 << (gi - 1);
      always_comb begin
        g_d = lvl[gi-1].st_g;
        for (int i = SPAN; i < WIDTH; i++) begin
          g_d[i] = lvl[gi-1].st_g[i] | (lvl[gi-1].g_p.st_p[i] & lvl[gi-1].st_g[i-SPAN]);
        end
        pr_d = lvl[gi-1].st_pr;
        c0_d = lvl[gi-1].st_c0;
        v_d  = lvl[gi-1].st_v;
      end
    end

    // Group propagate is only consumed by the following prefix level, so the
    // last level does not produce one.
    if (gi < L) begin : g_p
      logic [WIDTH-1:0] p_d, st_p;
      if (gi == 0) begin : g_p0
        assign p_d = pr_d;
      end else begin : g_pk
        localparam int SPAN = 1 << (gi - 1);
        always_comb begin
          p_d = lvl[gi-1].g_p.st_p;
          for (int i = SPAN; i < WIDTH; i++) begin
            p_d[i] = lvl[gi-1].g_p.st_p[i] & lvl[gi-1].g_p.st_p[i-SPAN];
          end
        end
      end
      if (PIPE) begin : g_pq
        logic [WIDTH-1:0] p_q;
        always_ff @(posedge clk) begin
          if (advance) p_q <= p_d;
        end
        assign st_p = p_q;
      end else begin : g_pw
        assign st_p = p_d;
      end
    end

    if (PIPE) begin : g_ff
      logic [WIDTH-1:0] g_q, pr_q;
      logic             c0_q, v_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       v_q <= 1'b0;
        else if (advance) v_q <= v_d;
      end
      // Data needs no reset: it is only ever observed qualified by its valid.
      always_ff @(posedge clk) begin
        if (advance) begin
          g_q  <= g_d;
          pr_q <= pr_d;
          c0_q <= c0_d;
        end
      end
      assign st_g  = g_q;
      assign st_pr = pr_q;
      assign st_c0 = c0_q;
      assign st_v  = v_q;
    end else begin : g_wire
      assign st_g  = g_d;
      assign st_pr = pr_d;
      assign st_c0 = c0_d;
      assign st_v  = v_d;
    end
  end

  // Output stage: carry into bit i is G of bits [i-1:0] (c0 for bit 0).
  logic [WIDTH-1:0] carry, sum_d, sum_q;
  logic             cout_d, ovf_d, out_valid_d, cout_q, ovf_q;

  always_comb begin
    carry       = {lvl[L].st_g[WIDTH-2:0], lvl[L].st_c0};
    sum_d       = lvl[L].st_pr ^ carry;
    cout_d      = lvl[L].st_g[WIDTH-1];
    ovf_d       = carry[WIDTH-1] ^ cout_d;
    out_valid_d = lvl[L].st_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       out_valid_q <= 1'b0;
    else if (advance) out_valid_q <= out_valid_d;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ks_adder_pipe.sv
module tb_ks_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 16-bit pipelined instance
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  // 5-bit combinational-prefix instance
  logic        in_valid_5, in_ready_5, cin_5, sub_5, out_valid_5, out_ready_5, cout_5, ovf_5;
  logic [4:0]  a_5, b_5, sum_5;

  int n_cmp = 0;
  int n_bad = 0;

  ks_adder_pipe #(.WIDTH(16), .PIPE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  ks_adder_pipe #(.WIDTH(5), .PIPE(1'b0)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_5), .in_ready(in_ready_5),
    .a(a_5), .b(b_5), .cin(cin_5), .sub(sub_5),
    .out_valid(out_valid_5), .out_ready(out_ready_5),
    .sum(sum_5), .cout(cout_5), .ovf(ovf_5)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition; returns {cout, ovf, sum}.
  function automatic logic [17:0] ref16(input logic [15:0] ra, input logic [15:0] rb,
                                         input logic rcin, input logic rsub);
    logic [15:0] bb;
    logic [16:0] f;
    logic        o;
    bb = rsub ? ~rb : rb;
    f  = {1'b0, ra} + {1'b0, bb} + {16'd0, (rsub ? 1'b1 : rcin)};
    o  = (ra[15] == bb[15]) && (f[15] != ra[15]);
    return {f[16], o, f[15:0]};
  endfunction

  function automatic logic [6:0] ref5(input logic [4:0] ra, input logic [4:0] rb,
                                       input logic rcin, input logic rsub);
    logic [4:0] bb;
    logic [5:0] f;
    logic       o;
    bb = rsub ? ~rb : rb;
    f  = {1'b0, ra} + {1'b0, bb} + {5'd0, (rsub ? 1'b1 : rcin)};
    o  = (ra[4] == bb[4]) && (f[4] != ra[4]);
    return {f[5], o, f[4:0]};
  endfunction

  // One beat through the 16-bit pipe with out_ready held high; checks latency and result.
  task automatic beat16(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                        input logic tsub, input logic [17:0] exp, input string tag);
    int lat;
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    lat = 1;
    #1 in_valid = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd6);
    chk({tag, "_result"}, 64'({cout, ovf, sum}), 64'(exp));
    $display("beat16 %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             tag, ta, tb, tcin, tsub, sum, cout, ovf, lat);
    @(posedge clk);
  endtask

  task automatic beat5(input logic [4:0] ta, input logic [4:0] tb, input logic tcin,
                       input logic tsub, input logic [6:0] exp, input string tag);
    @(negedge clk);
    a_5 = ta; b_5 = tb; cin_5 = tcin; sub_5 = tsub; in_valid_5 = 1'b1; out_ready_5 = 1'b1;
    @(posedge clk);
    #1 in_valid_5 = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, 64'(out_valid_5), 64'd1);
    chk({tag, "_result"}, 64'({cout_5, ovf_5, sum_5}), 64'(exp));
    $display("beat5 %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
             tag, ta, tb, tcin, tsub, sum_5, cout_5, ovf_5);
  endtask

  initial begin
    logic [17:0] q[$];
    logic [17:0] held;
    logic        stall_prev;
    int          sent, got, waitc;
    logic [4:0]  ra5, rb5;
    logic        rc5, rs5;

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid_5 = 1'b0; out_ready_5 = 1'b0; a_5 = '0; b_5 = '0; cin_5 = 1'b0; sub_5 = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid5", 64'(out_valid_5), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, 16-bit pipelined
    beat16(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000}, "pos_ovf");
    beat16(16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 16'h0000}, "cin_ripple");
    beat16(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE}, "sub_borrow");
    beat16(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}, "sub_ovf");
    beat16(16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555}, "plain");
    beat16(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000}, "neg_ovf");
    beat16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {1'b1, 1'b0, 16'hFFFF}, "all_ones");
    beat16(16'h0000, 16'h0000, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0000}, "sub_zero");

    // Back-pressure stream: 20 random beats, random out_ready
    sent = 0; got = 0; stall_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
      @(negedge clk);
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'({cout, ovf, sum}), 64'(held));
      end
      if (sent < 20) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stream_extra", 64'd1, 64'd0);
        end else begin
          chk("stream_data", 64'({cout, ovf, sum}), 64'(q.pop_front()));
          $display("stream result %0d sum=%h cout=%0d ovf=%0d", got, sum, cout, ovf);
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref16(a, b, cin, sub));
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      held = {cout, ovf, sum};
    end
    in_valid = 1'b0;
    chk("stream_count", 64'(got), 64'd20);
    chk("stream_leftover", 64'(q.size()), 64'd0);

    // Reset mid-stream: 4 beats in, stall at the output, then async reset
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 16'(i + 1); b = 16'h0100; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    waitc = 0;
    while (!out_valid && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("rstm_reached_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_async_valid", 64'(out_valid), 64'd0);
    chk("rstm_in_ready", 64'(in_ready), 64'd1);
    $display("mid-stream reset asserted, out_valid=%0d", out_valid);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rstm_no_ghost", 64'(out_valid), 64'd0);
    end
    beat16(16'h0F0F, 16'h00F1, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000}, "after_rst");

    // 5-bit combinational-prefix instance, latency 1
    beat5(5'h0F, 5'h01, 1'b0, 1'b0, {1'b0, 1'b1, 5'h10}, "w5_ovf");
    beat5(5'h00, 5'h01, 1'b1, 1'b1, {1'b0, 1'b0, 5'h1F}, "w5_sub");
    beat5(5'h1F, 5'h00, 1'b1, 1'b0, {1'b1, 1'b0, 5'h00}, "w5_ripple");
    for (int i = 0; i < 30; i++) begin
      ra5 = 5'($urandom); rb5 = 5'($urandom);
      rc5 = 1'($urandom_range(0, 1)); rs5 = 1'($urandom_range(0, 1));
      beat5(ra5, rb5, rc5, rs5, ref5(ra5, rb5, rc5, rs5), "w5_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
